// File: rtl/rspreturn.sv
// Response-return path beside the request decoder: tracks the granted slave and outstanding
// count, routes slave acks back to the master, and answers "no slave" requests with bus errors.
// Build option: define RSPRETURN_FAULT_EN to enable the sticky o_fault protocol monitor.
module rspreturn #(
  parameter int NS           = 1,
  parameter int DW           = 32,
  parameter int LGDEPTH      = 3,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_abort,
  input  logic             i_req_valid,
  input  logic [NS:0]      i_req_decode,
  output logic             o_req_stall,
  input  logic [NS-1:0]    i_rsp_ack,
  input  logic [NS-1:0]    i_rsp_err,
  input  logic [NS*DW-1:0] i_rsp_data,
  output logic             o_rsp_valid,
  output logic             o_rsp_err,
  output logic [DW-1:0]    o_rsp_data,
  output logic             o_busy,
  output logic             o_fault
);

  localparam logic [LGDEPTH:0] MAX_COUNT = {1'b1, {LGDEPTH{1'b0}}};
  localparam logic [LGDEPTH:0] ONE       = {{LGDEPTH{1'b0}}, 1'b1};

  logic [LGDEPTH:0] r_count;
  logic [NS:0]      r_grant;

  logic             count_nz;
  logic             count_full;
  logic             accept;
  logic             inc;
  logic             ack_ok;
  logic             nsel_ok;
  logic             retire;
  logic [NS-1:0]    granted_ack;
  logic             slave_err;
  logic [DW-1:0]    slave_data;

  assign count_nz   = (r_count != '0);
  assign count_full = (r_count == MAX_COUNT);

  // A new target is only taken once every response of the old target has retired.
  assign o_req_stall = i_req_valid
                     && ((count_nz && (i_req_decode != r_grant)) || count_full || i_abort);
  assign accept      = i_req_valid && !o_req_stall;
  assign inc         = accept && (|i_req_decode);

  assign granted_ack = i_rsp_ack & r_grant[NS-1:0];
  assign ack_ok      = count_nz && (|granted_ack);
  assign nsel_ok     = count_nz && r_grant[NS];
  assign retire      = (ack_ok || nsel_ok) && !i_abort;

  assign o_busy = count_nz;

  // Grant is one-hot, so an AND-OR mux selects the single granted slave.
  always_comb begin
    slave_data = '0;
    slave_err  = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (r_grant[k]) begin
        slave_data = slave_data | i_rsp_data[k*DW +: DW];
        slave_err  = slave_err | (i_rsp_ack[k] & i_rsp_err[k]);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
      r_grant <= '0;
    end else if (i_abort) begin
      r_count <= '0;
      r_grant <= '0;
    end else begin
      if (accept) begin
        r_grant <= i_req_decode;
      end
      case ({inc, retire})
        2'b10:   r_count <= r_count + ONE;
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the response data register is reset too, because outputs must read zero
  // during reset; it is a single word, not a memory, so the reset cost is trivial.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_data  <= '0;
    end else begin
      o_rsp_valid <= retire;
      if (retire) begin
        o_rsp_err  <= nsel_ok ? 1'b1 : slave_err;
        o_rsp_data <= nsel_ok ? '0 : slave_data;
      end else begin
        o_rsp_err <= 1'b0;
        if (OPT_LOWPOWER) begin
          o_rsp_data <= '0;
        end
      end
    end
  end

`ifdef RSPRETURN_FAULT_EN
  logic stray_ack;
  logic zero_req;
  logic r_fault;

  // Any ack outside the grant, or any ack with nothing outstanding, is a protocol fault.
  assign stray_ack = (|(i_rsp_ack & ~r_grant[NS-1:0])) || (!count_nz && (|i_rsp_ack));
  assign zero_req  = accept && (i_req_decode == '0);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fault <= 1'b0;
    end else if (!i_abort && (stray_ack || zero_req)) begin
      r_fault <= 1'b1;
    end
  end

  assign o_fault = r_fault;
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_rspreturn.sv
// Directed bench for rspreturn (NS=2, LGDEPTH=3): stimulus pushes expected responses into a
// queue, a separate monitor pops and compares whenever o_rsp_valid is seen.
module tb_rspreturn;

  localparam int NS      = 2;
  localparam int DW      = 32;
  localparam int LGDEPTH = 3;

`ifdef RSPRETURN_FAULT_EN
  localparam logic FAULT_EXP = 1'b1;
`else
  localparam logic FAULT_EXP = 1'b0;
`endif

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  logic             i_clk;
  logic             i_reset_n;
  logic             i_abort;
  logic             i_req_valid;
  logic [NS:0]      i_req_decode;
  logic             o_req_stall;
  logic [NS-1:0]    i_rsp_ack;
  logic [NS-1:0]    i_rsp_err;
  logic [NS*DW-1:0] i_rsp_data;
  logic             o_rsp_valid;
  logic             o_rsp_err;
  logic [DW-1:0]    o_rsp_data;
  logic             o_busy;
  logic             o_fault;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  rspreturn #(.NS(NS), .DW(DW), .LGDEPTH(LGDEPTH), .OPT_LOWPOWER(1'b0)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_abort      (i_abort),
    .i_req_valid  (i_req_valid),
    .i_req_decode (i_req_decode),
    .o_req_stall  (o_req_stall),
    .i_rsp_ack    (i_rsp_ack),
    .i_rsp_err    (i_rsp_err),
    .i_rsp_data   (i_rsp_data),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_err    (o_rsp_err),
    .o_rsp_data   (o_rsp_data),
    .o_busy       (o_busy),
    .o_fault      (o_fault)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_abort      = 1'b0;
    i_req_valid  = 1'b0;
    i_req_decode = '0;
    i_rsp_ack    = '0;
    i_rsp_err    = '0;
    i_rsp_data   = '0;
  endtask

  task automatic request(input logic [NS:0] dec);
    i_req_valid  = 1'b1;
    i_req_decode = dec;
  endtask

  // Drive one slave ack and record the response it must produce one cycle later.
  task automatic ack(input int k, input logic err, input logic [DW-1:0] data, input logic expect_rsp);
    rsp_t r;
    i_rsp_ack            = '0;
    i_rsp_err            = '0;
    i_rsp_ack[k]         = 1'b1;
    i_rsp_err[k]         = err;
    i_rsp_data           = '0;
    i_rsp_data[k*DW +: DW] = data;
    if (expect_rsp) begin
      r.err  = err;
      r.data = data;
      exp_q.push_back(r);
    end
  endtask

  task automatic push_nsel();
    rsp_t r;
    r.err  = 1'b1;
    r.data = '0;
    exp_q.push_back(r);
  endtask

  // Monitor: every response the DUT presents must match the oldest expected entry.
  initial begin
    rsp_t r;
    forever begin
      @(negedge i_clk);
      if (i_reset_n && o_rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got valid err=%0b data=0x%0h, expected no response at %0t",
                   o_rsp_err, o_rsp_data, $time);
        end else begin
          r = exp_q.pop_front();
          check("rsp_err", {63'd0, o_rsp_err}, {63'd0, r.err});
          check("rsp_data", {32'd0, o_rsp_data}, {32'd0, r.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    idle();
    i_reset_n = 1'b0;
    #3;
    check("reset_valid", {63'd0, o_rsp_valid}, 64'd0);
    check("reset_err",   {63'd0, o_rsp_err},   64'd0);
    check("reset_data",  {32'd0, o_rsp_data},  64'd0);
    check("reset_busy",  {63'd0, o_busy},      64'd0);
    check("reset_fault", {63'd0, o_fault},     64'd0);
    check("reset_stall", {63'd0, o_req_stall}, 64'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    step();

    // Three requests to slave 0, then three back-to-back acks.
    for (int i = 0; i < 3; i++) begin
      request(3'b001);
      #1 check("a_accept_stall", {63'd0, o_req_stall}, 64'd0);
      step();
    end
    idle();
    check("a_busy", {63'd0, o_busy}, 64'd1);
    ack(0, 1'b0, 32'hA0, 1'b1); step();
    ack(0, 1'b1, 32'hA1, 1'b1); step();
    ack(0, 1'b0, 32'hA2, 1'b1); step();
    idle();
    check("a_busy_low", {63'd0, o_busy}, 64'd0);
    check("a_last_valid", {63'd0, o_rsp_valid}, 64'd1);
    step();

    // Switching targets waits for the last slave-0 response.
    request(3'b001); step();
    request(3'b010);
    #1 check("b_switch_stall", {63'd0, o_req_stall}, 64'd1);
    step();
    check("b_switch_stall2", {63'd0, o_req_stall}, 64'd1);
    ack(0, 1'b0, 32'h0000_00B0, 1'b1);
    #1 check("b_stall_on_retire", {63'd0, o_req_stall}, 64'd1);
    step();
    i_rsp_ack = '0;
    #1 check("b_accept_after", {63'd0, o_req_stall}, 64'd0);
    step();
    i_req_valid = 1'b0;
    check("b_busy", {63'd0, o_busy}, 64'd1);
    ack(1, 1'b1, 32'hB1B1_0001, 1'b1); step();
    idle();
    check("b_busy_low", {63'd0, o_busy}, 64'd0);
    step();

    // Two requests to "no slave" produce two error responses without any ack.
    i_rsp_data = {32'h5555_5555, 32'hAAAA_AAAA};
    request(3'b100); push_nsel(); step();
    request(3'b100); push_nsel();
    #1 check("c_second_accept", {63'd0, o_req_stall}, 64'd0);
    step();
    i_req_valid = 1'b0;
    step();
    idle();
    check("c_busy_low", {63'd0, o_busy}, 64'd0);
    step();

    // Fill to the limit, then overlap an ack with a new request at count 7.
    for (int i = 0; i < 8; i++) begin
      request(3'b010);
      #1 check("d_fill_stall", {63'd0, o_req_stall}, 64'd0);
      step();
    end
    #1 check("d_full_stall", {63'd0, o_req_stall}, 64'd1);
    step();
    ack(1, 1'b0, 32'hD000_0000, 1'b1);
    #1 check("d_full_stall_on_ack", {63'd0, o_req_stall}, 64'd1);
    step();
    ack(1, 1'b0, 32'hD000_0001, 1'b1);
    #1 check("d_ack_and_req_stall", {63'd0, o_req_stall}, 64'd0);
    step();
    i_req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ack(1, 1'b0, 32'hD000_0010 + DW'(i), 1'b1);
      step();
      check("d_drain_busy", {63'd0, o_busy}, (i == 6) ? 64'd0 : 64'd1);
    end
    idle();
    step();

    // Stray ack from slave 1 while slave 0 is granted.
    request(3'b001); step();
    idle();
    ack(1, 1'b0, 32'hEEEE_0001, 1'b0); step();
    idle();
    check("e_fault", {63'd0, o_fault}, {63'd0, FAULT_EXP});
    check("e_still_busy", {63'd0, o_busy}, 64'd1);
    ack(0, 1'b0, 32'hE0, 1'b1); step();
    idle();
    check("e_busy_low", {63'd0, o_busy}, 64'd0);
    step();

    // Zero decode is accepted but never counted.
    request(3'b000);
    #1 check("z_stall", {63'd0, o_req_stall}, 64'd0);
    step();
    idle();
    check("z_busy", {63'd0, o_busy}, 64'd0);
    check("z_fault", {63'd0, o_fault}, {63'd0, FAULT_EXP});

    // Abort with four outstanding; later acks are dropped.
    for (int i = 0; i < 4; i++) begin
      request(3'b001); step();
    end
    idle();
    i_abort = 1'b1;
    request(3'b001);
    ack(0, 1'b0, 32'hF0, 1'b0);
    #1 check("f_abort_stall", {63'd0, o_req_stall}, 64'd1);
    step();
    idle();
    check("f_busy_low", {63'd0, o_busy}, 64'd0);
    ack(0, 1'b0, 32'hF1, 1'b0); step();
    ack(0, 1'b0, 32'hF2, 1'b0); step();
    idle();
    step();
    request(3'b001); step();
    idle();
    ack(0, 1'b0, 32'hF3, 1'b1); step();
    idle();
    step();

    // Asynchronous reset while a response is pending.
    request(3'b001); step();
    request(3'b001); step();
    idle();
    ack(0, 1'b0, 32'h77, 1'b0);
    @(posedge i_clk);
    #1;
    idle();
    check("g_pending_valid", {63'd0, o_rsp_valid}, 64'd1);
    #1 i_reset_n = 1'b0;
    #1;
    check("g_rst_valid", {63'd0, o_rsp_valid}, 64'd0);
    check("g_rst_data",  {32'd0, o_rsp_data},  64'd0);
    check("g_rst_busy",  {63'd0, o_busy},      64'd0);
    check("g_rst_fault", {63'd0, o_fault},     64'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    step();
    check("g_busy_after", {63'd0, o_busy}, 64'd0);

    repeat (3) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
